tx_pkt_buffer: RTL and testbench

TX_PKT_BUFFER -- requirements
Module: tx_pkt_buffer

---
 rtl/tx_pkt_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_tx_pkt_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_buffer.sv
// tx_pkt_buffer: store-and-forward TX buffer between packet composer and MAC.
// Packets are committed on a good EOP and streamed out with sop/eop/empty.
module tx_pkt_buffer #(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH/8,
  parameter int BUF_ADDR_WIDTH = 9,
  parameter int MAX_PKTS       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_wr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  in_rdy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [2:0]            out_empty,
  input  logic                  out_ready,
  output logic [31:0]           pkt_sent_cnt,
  output logic [31:0]           pkt_drop_cnt
);
  localparam int AW = BUF_ADDR_WIDTH;
  localparam int PW = $clog2(MAX_PKTS);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IN_IDLE, IN_PKT, IN_DROP} in_st_t;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} out_st_t;

  logic [DATA_WIDTH-1:0] r_mem [1<<AW];
  // descriptor keeps {byte_len[2:0], word_count}; only the residue
  // of byte_len matters once the length check has passed
  logic [18:0]           r_desc [MAX_PKTS];
  logic [DATA_WIDTH-1:0] r_ram_q;

  in_st_t      r_in_st;
  out_st_t     r_out_st;
  logic [AW:0] r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [PW:0] r_dwr, r_drd, r_pkt_cnt;
  logic [15:0] r_len, r_wcnt, r_left;
  logic [2:0]  r_emp;
  logic        r_first, r_live;
  logic        r_ovalid, r_osop, r_oeop;
  logic [2:0]  r_oempty;
  logic [DATA_WIDTH-1:0] r_odata;
  logic [31:0] r_sent, r_drop;

  logic        w_hdr, w_body, w_eop, w_dat;
  logic        w_full, w_dfull, w_len_ok;
  logic        w_store, w_commit, w_done;
  logic [AW:0] w_used, w_free, w_raddr;
  logic [15:0] w_wcnt_nx;
  logic [16:0] w_need;
  logic [18:0] w_desc;

  assign w_hdr  = in_wr && (&in_ctrl);
  assign w_body = in_wr && (in_ctrl == '0);
  assign w_eop  = in_wr && !(&in_ctrl) && (in_ctrl != '0);
  assign w_dat  = w_body || w_eop;

  assign w_used = r_wr_ptr - r_rd_ptr;
  assign w_full = (w_used == DEPTH);
  assign w_free = DEPTH - (r_cm_ptr - r_rd_ptr);
  // outstanding count includes the packet being sent
  assign w_dfull = r_pkt_cnt[PW];
  assign in_rdy  = r_live && !w_dfull &&
                   (w_free >= {{(AW-1){1'b0}}, 2'd2});

  assign w_wcnt_nx = r_wcnt + 16'd1;
  assign w_need    = ({1'b0, r_len} + 17'd7) >> 3;
  assign w_len_ok  = (r_len != 16'd0) &&
                     (w_need == {1'b0, w_wcnt_nx});

  assign w_store  = w_dat && (r_in_st == IN_PKT) && !w_full;
  assign w_commit = w_store && w_eop && w_len_ok && !w_dfull;
  assign w_done   = (r_out_st == SEND) && out_ready && r_oeop;

  assign w_raddr = ((r_out_st == SEND) && out_ready) ?
                   r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_desc  = r_desc[r_drd[PW-1:0]];

  assign out_valid    = r_ovalid;
  assign out_data     = r_odata;
  assign out_sop      = r_osop;
  assign out_eop      = r_oeop;
  assign out_empty    = r_oempty;
  assign pkt_sent_cnt = r_sent;
  assign pkt_drop_cnt = r_drop;

  // data RAM: write at accept, registered read every cycle
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    r_ram_q <= r_mem[w_raddr[AW-1:0]];
  end

  // descriptor ring storage, written on commit
  always_ff @(posedge clk) begin
    if (w_commit)
      r_desc[r_dwr[PW-1:0]] <= {r_len[2:0], w_wcnt_nx};
  end

  // input side: track open packet, commit on good EOP or rewind
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_st  <= IN_IDLE;
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_dwr    <= '0;
      r_drop   <= '0;
    end else if (w_hdr) begin
      if (r_in_st == IN_PKT) r_drop <= r_drop + 32'd1;
      r_wr_ptr <= r_cm_ptr;
      r_len    <= in_data[15:0];
      r_wcnt   <= '0;
      r_in_st  <= IN_PKT;
    end else if (w_dat && r_in_st == IN_DROP) begin
      if (w_eop) r_in_st <= IN_IDLE;
    end else if (w_dat && r_in_st == IN_PKT) begin
      if (w_full) begin
        r_drop   <= r_drop + 32'd1;
        r_wr_ptr <= r_cm_ptr;
        r_in_st  <= w_eop ? IN_IDLE : IN_DROP;
      end else if (w_body) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_wcnt   <= w_wcnt_nx;
      end else if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_cm_ptr <= r_wr_ptr + 1'b1;
        r_dwr    <= r_dwr + 1'b1;
        r_in_st  <= IN_IDLE;
      end else begin
        r_drop   <= r_drop + 32'd1;
        r_wr_ptr <= r_cm_ptr;
        r_in_st  <= IN_IDLE;
      end
    end
  end

  // packets committed but not yet fully sent
  always_ff @(posedge clk) begin
    if (reset) r_pkt_cnt <= '0;
    else r_pkt_cnt <= r_pkt_cnt + {{PW{1'b0}}, w_commit}
                                - {{PW{1'b0}}, w_done};
  end

  // in_rdy stays low until the first cycle out of reset
  always_ff @(posedge clk) begin
    if (reset) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  // output FSM: pop descriptor, wait RAM latency, hold until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_st <= IDLE;
      r_rd_ptr <= '0;
      r_drd    <= '0;
      r_left   <= '0;
      r_emp    <= '0;
      r_first  <= 1'b0;
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_osop   <= 1'b0;
      r_oeop   <= 1'b0;
      r_oempty <= '0;
      r_sent   <= '0;
    end else begin
      case (r_out_st)
        IDLE: if (r_drd != r_dwr) begin
          r_left   <= w_desc[15:0];
          r_emp    <= 3'd0 - w_desc[18:16];
          r_first  <= 1'b1;
          r_drd    <= r_drd + 1'b1;
          r_out_st <= FETCH;
        end
        FETCH: begin
          r_ovalid <= 1'b1;
          r_odata  <= r_ram_q;
          r_osop   <= r_first;
          r_oeop   <= (r_left == 16'd1);
          r_oempty <= (r_left == 16'd1) ? r_emp : 3'd0;
          r_out_st <= SEND;
        end
        SEND: if (out_ready) begin
          r_ovalid <= 1'b0;
          r_osop   <= 1'b0;
          r_oeop   <= 1'b0;
          r_oempty <= '0;
          r_rd_ptr <= r_rd_ptr + 1'b1;
          if (r_oeop) begin
            r_sent   <= r_sent + 32'd1;
            r_out_st <= IDLE;
          end else begin
            r_left   <= r_left - 16'd1;
            r_first  <= 1'b0;
            r_out_st <= FETCH;
          end
        end
        default: r_out_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_pkt_buffer.sv
// tb_tx_pkt_buffer: table-driven packet vectors plus hand sequences;
// expected output words go through a scoreboard queue.
module tb_tx_pkt_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_wr = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_rdy;
  logic        out_valid, out_sop, out_eop;
  logic [63:0] out_data;
  logic [2:0]  out_empty;
  logic        out_ready = 1'b1;
  logic [31:0] pkt_sent_cnt, pkt_drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_sent = 0;
  int exp_drop = 0;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  emp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        hdr;
    logic [15:0] len;
    int          nw;
    logic [7:0]  ec;
    logic        ok;
    logic [2:0]  emp;
  } vec_t;
  vec_t tv[9];

  tx_pkt_buffer dut (
    .clk(clk), .reset(reset),
    .in_wr(in_wr), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_rdy(in_rdy),
    .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_ready(out_ready),
    .pkt_sent_cnt(pkt_sent_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // scoreboard monitor: compare every accepted word
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h sop=%b eop=%b",
                 out_data, out_sop, out_eop);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_data, out_sop, out_eop, out_empty} !==
            {e.d, e.sop, e.eop, e.emp}) begin
          errors++;
          $display("FAIL out_word: got %h/%b/%b/%0d expected %h/%b/%b/%0d",
                   out_data, out_sop, out_eop, out_empty,
                   e.d, e.sop, e.eop, e.emp);
        end
      end
    end
  end

  task automatic send_word(input logic [7:0] c, input logic [63:0] d);
    int n = 0;
    while (!in_rdy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_wait: got 0 expected 1");
    end
    in_wr = 1'b1;
    in_ctrl = c;
    in_data = d;
    @(posedge clk); #1;
    in_wr = 1'b0;
    in_ctrl = '0;
  endtask

  task automatic send_pkt(input logic hdr, input logic [15:0] len,
                          input int nw, input logic [7:0] ec,
                          input logic ok, input logic [2:0] emp);
    logic [63:0] d;
    exp_t e;
    if (hdr) send_word(8'hFF, {$urandom, 16'hABCD, len});
    for (int k = 0; k < nw; k++) begin
      d = {$urandom, $urandom};
      if (ok) begin
        e.d = d;
        e.sop = (k == 0);
        e.eop = (k == nw - 1);
        e.emp = (k == nw - 1) ? emp : 3'd0;
        sb.push_back(e);
      end
      send_word((k == nw - 1) ? ec : 8'h00, d);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_sent"}, pkt_sent_cnt, exp_sent);
    chk({tag, "_drop"}, pkt_drop_cnt, exp_drop);
  endtask

  initial begin
    logic [63:0] d0;
    int base;
    int n;
    tv[0] = '{1'b1, 16'h14, 3, 8'h0F, 1'b1, 3'd4};
    tv[1] = '{1'b1, 16'd8,  1, 8'h80, 1'b1, 3'd0};
    tv[2] = '{1'b1, 16'd1,  1, 8'h01, 1'b1, 3'd7};
    tv[3] = '{1'b1, 16'd0,  1, 8'h01, 1'b0, 3'd0};
    tv[4] = '{1'b1, 16'd20, 2, 8'h0F, 1'b0, 3'd0};
    tv[5] = '{1'b1, 16'd64, 8, 8'h7F, 1'b1, 3'd0};
    tv[6] = '{1'b0, 16'd0,  2, 8'h01, 1'b0, 3'd0};
    tv[7] = '{1'b1, 16'd17, 3, 8'h01, 1'b1, 3'd7};
    tv[8] = '{1'b1, 16'd16, 3, 8'h03, 1'b0, 3'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_empty", out_empty, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rdy", in_rdy, 0);
    chk_cnt("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", in_rdy, 1);

    for (int i = 0; i < 9; i++) begin
      send_pkt(tv[i].hdr, tv[i].len, tv[i].nw, tv[i].ec,
               tv[i].ok, tv[i].emp);
      drain();
      if (tv[i].ok) exp_sent++;
      else if (tv[i].hdr) exp_drop++;
      chk_cnt($sformatf("vec%0d", i));
    end

    out_ready = 1'b0;
    send_pkt(1'b1, 16'd24, 3, 8'h01, 1'b1, 3'd0);
    d0 = sb[0].d;
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_data", out_data, d0);
      chk("stall_sop", out_sop, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    exp_sent++;
    chk_cnt("stall");

    out_ready = 1'b0;
    base = exp_sent;
    for (int k = 0; k < 16; k++)
      send_pkt(1'b1, 16'd8, 1, 8'h01, 1'b1, 3'd0);
    chk("full16_rdy", in_rdy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("full16_rdy_hold", in_rdy, 0);
    out_ready = 1'b1;
    n = 0;
    while (!in_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("full16_rdy_back", in_rdy, 1);
    chk("full16_sent_at_rdy", pkt_sent_cnt, base + 1);
    send_pkt(1'b1, 16'd8, 1, 8'h01, 1'b1, 3'd0);
    drain();
    exp_sent += 17;
    chk_cnt("full16");

    send_word(8'hFF, {48'h0, 16'd16});
    send_word(8'h00, {$urandom, $urandom});
    send_pkt(1'b1, 16'd16, 2, 8'h01, 1'b1, 3'd0);
    drain();
    exp_drop++;
    exp_sent++;
    chk_cnt("midhdr");

    send_word(8'hFF, {48'h0, 16'd4800});
    for (int k = 0; k < 599; k++)
      send_word(8'h00, {$urandom, $urandom});
    send_word(8'h01, {$urandom, $urandom});
    drain();
    exp_drop++;
    chk_cnt("oversize");
    send_pkt(1'b1, 16'd40, 5, 8'h01, 1'b1, 3'd0);
    drain();
    exp_sent++;
    chk_cnt("after_oversize");

    out_ready = 1'b0;
    send_pkt(1'b1, 16'd24, 3, 8'h01, 1'b1, 3'd0);
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid();
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    exp_sent = 0;
    exp_drop = 0;
    chk("midrst_valid", out_valid, 0);
    chk_cnt("midrst");
    reset = 1'b0;
    out_ready = 1'b1;
    send_pkt(1'b1, 16'h14, 3, 8'h0F, 1'b1, 3'd4);
    drain();
    exp_sent++;
    chk_cnt("post_rst");

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
